// File: rtl/hdlc_rx_deframer_if.sv
// hdlc_rx_deframer_if: serial line input and deframed byte/status outputs of the HDLC receiver
interface hdlc_rx_deframer_if #(
  parameter int CNT_W = 8
);
  logic Rx;
  logic RxEN;
  logic [7:0] Rx_Data;
  logic Rx_NewByte;
  logic Rx_ValidFrame;
  logic Rx_FlagDetect;
  logic Rx_AbortDetect;
  logic Rx_EoF;
  logic Rx_FrameError;
  logic [CNT_W-1:0] Rx_ByteCount;
  modport master (
    output Rx, RxEN,
    input Rx_Data, Rx_NewByte, Rx_ValidFrame, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError, Rx_ByteCount
  );
  modport slave (
    input Rx, RxEN,
    output Rx_Data, Rx_NewByte, Rx_ValidFrame, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError, Rx_ByteCount
  );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: HDLC Rx flag/abort detection, zero removal and byte framing; HDLC_RX_BYTECNT_EN builds Rx_ByteCount
module hdlc_rx_deframer #(
  parameter int CNT_W = 8
) (
  input logic Clk,
  input logic Rst,
  hdlc_rx_deframer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, FRAME} state_t;
  state_t state_q;
  logic [7:0] sr_q, sr_d, dtag_q, dtag_d, acc_q, acc_d, data_q;
  logic [2:0] run_q, run_d, bitcnt_q, bitcnt_d;
  logic newbyte_q, valid_q, flag_q, abort_q, end_q, err_q, eof_q, ferr_q;
  logic en, flag_m, abort_m, match, newtag, accept, done;
  assign en = bus.RxEN;
  assign flag_m = en && sr_q == 8'h7E;
  assign abort_m = en && sr_q == 8'hFE;
  assign match = flag_m || abort_m;
  assign newtag = !bus.Rx && run_q == 3'd5;
  // dtag[0] marks the popped bit as a stuffed zero or a flag/abort remnant
  assign accept = en && !match && !dtag_q[0] && state_q != IDLE;
  assign done = accept && bitcnt_q == 3'd7;
  always_comb begin
    sr_d = en ? {bus.Rx, sr_q[7:1]} : 8'hFF;
    dtag_d = !en ? 8'hFF : match ? {newtag, 7'h7F} : {newtag, dtag_q[7:1]};
    run_d = !en || !bus.Rx ? 3'd0 : run_q == 3'd7 ? run_q : run_q + 3'd1;
    acc_d = accept ? {sr_q[0], acc_q[7:1]} : !en || match ? 8'h00 : acc_q;
    bitcnt_d = accept ? bitcnt_q + 3'd1 : !en || match ? 3'd0 : bitcnt_q;
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      sr_q <= 8'hFF;
      dtag_q <= 8'hFF;
      run_q <= 3'd0;
      acc_q <= 8'h00;
      bitcnt_q <= 3'd0;
      data_q <= 8'h00;
      newbyte_q <= 1'b0;
      valid_q <= 1'b0;
      flag_q <= 1'b0;
      abort_q <= 1'b0;
      end_q <= 1'b0;
      err_q <= 1'b0;
      eof_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= !en || abort_m ? IDLE : flag_m ? ARMED : done && state_q == ARMED ? FRAME : state_q;
      sr_q <= sr_d;
      dtag_q <= dtag_d;
      run_q <= run_d;
      acc_q <= acc_d;
      bitcnt_q <= bitcnt_d;
      data_q <= done ? acc_d : data_q;
      newbyte_q <= done;
      valid_q <= !en || match ? 1'b0 : done && state_q == ARMED ? 1'b1 : valid_q;
      flag_q <= flag_m;
      abort_q <= abort_m;
      end_q <= valid_q && (!en || match);
      err_q <= valid_q && flag_m && bitcnt_q != 3'd0;
      eof_q <= end_q;
      ferr_q <= err_q;
    end
  end
`ifdef HDLC_RX_BYTECNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) cnt_q <= '0;
    else if (done) cnt_q <= state_q == ARMED ? CNT_W'(1) : cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
  end
  assign bus.Rx_ByteCount = cnt_q;
`else
  assign bus.Rx_ByteCount = {CNT_W{1'b0}};
`endif
  assign bus.Rx_Data = data_q;
  assign bus.Rx_NewByte = newbyte_q;
  assign bus.Rx_ValidFrame = valid_q;
  assign bus.Rx_FlagDetect = flag_q;
  assign bus.Rx_AbortDetect = abort_q;
  assign bus.Rx_EoF = eof_q;
  assign bus.Rx_FrameError = ferr_q;
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: table-driven frames plus flag/abort/disable/reset sequences, bytes checked via a scoreboard queue
module tb_hdlc_rx_deframer;
  localparam int CNT_W = 8;
`ifdef HDLC_RX_BYTECNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  hdlc_rx_deframer_if #(.CNT_W(CNT_W)) bus ();
  hdlc_rx_deframer #(.CNT_W(CNT_W)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;

  typedef struct {
    int n;
    logic [2:0][7:0] b;
    int xbits;
    logic ferr;
    int cnt;
  } frame_t;

  int total = 0, bad = 0, cyc = 0, bitcyc = 0, ones = 0;
  int n_flag = 0, n_abort = 0, n_eof = 0, n_ferr = 0, n_nb = 0, n_vf = 0;
  int flag_cyc = 0, abort_cyc = 0;
  logic vf_p1 = 1'b0, vf_p2 = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic observe();
    if (bus.Rx_NewByte) begin
      n_nb++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_newbyte: got data %0h with no byte expected", bus.Rx_Data);
      end else check("rx_data", bus.Rx_Data, exp_q.pop_front());
    end
    if (bus.Rx_ValidFrame) n_vf++;
    if (bus.Rx_ValidFrame && !vf_p1) check("vf_rise_with_newbyte", bus.Rx_NewByte, 1);
    if (!bus.Rx_ValidFrame && vf_p1) check("vf_fall_cause", bus.Rx_FlagDetect | bus.Rx_AbortDetect | !bus.RxEN, 1);
    if (bus.Rx_EoF) begin
      n_eof++;
      check("eof_after_fall", {vf_p2, vf_p1}, 2'b10);
    end
    if (bus.Rx_FrameError) begin
      n_ferr++;
      check("ferr_with_eof", bus.Rx_EoF, 1);
    end
    if (bus.Rx_FlagDetect) begin
      n_flag++;
      flag_cyc = cyc;
    end
    if (bus.Rx_AbortDetect) begin
      n_abort++;
      abort_cyc = cyc;
    end
    vf_p2 = vf_p1;
    vf_p1 = bus.Rx_ValidFrame;
  endtask

  task automatic step(input logic b);
    bus.Rx = b;
    bitcyc = cyc;
    @(posedge Clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic send_bit(input logic b);
    step(b);
    ones = b ? ones + 1 : 0;
    if (ones == 5) begin
      step(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    exp_q.push_back(v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f = 8'h7E;
    for (int i = 0; i < 8; i++) step(f[i]);
    ones = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    frame_t tbl [4];
    int s0, s1, s2, s3, t, ta;
    tbl[0] = '{n: 2, b: {8'h00, 8'h3C, 8'hA5}, xbits: 0, ferr: 1'b0, cnt: 2};
    tbl[1] = '{n: 2, b: {8'h00, 8'h01, 8'hFF}, xbits: 0, ferr: 1'b0, cnt: 2};
    tbl[2] = '{n: 1, b: {8'h00, 8'h00, 8'h55}, xbits: 3, ferr: 1'b1, cnt: 1};
    tbl[3] = '{n: 3, b: {8'hFE, 8'h00, 8'h7E}, xbits: 0, ferr: 1'b0, cnt: 3};
    bus.Rx = 1'b1;
    bus.RxEN = 1'b1;
    #2 Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outputs", {bus.Rx_Data, bus.Rx_NewByte, bus.Rx_ValidFrame, bus.Rx_FlagDetect,
      bus.Rx_AbortDetect, bus.Rx_EoF, bus.Rx_FrameError, bus.Rx_ByteCount}, 0);
    Rst = 1'b1;
    repeat (12) step(1'b1);
    // flag from idle, then 1s: the flag's last 0 plus seven 1s is the single abort
    s0 = n_flag; s1 = n_abort; s2 = n_vf;
    send_flag();
    t = bitcyc;
    ta = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (i == 6) ta = bitcyc;
    end
    check("flag_count", n_flag - s0, 1);
    check("flag_latency", flag_cyc - t, 2);
    check("idle_abort_count", n_abort - s1, 1);
    check("idle_abort_latency", abort_cyc - ta, 2);
    check("no_valid_without_data", n_vf - s2, 0);
    for (int k = 0; k < 4; k++) begin
      s0 = n_eof; s1 = n_ferr; s2 = n_nb;
      send_flag();
      for (int i = 0; i < tbl[k].n; i++) send_byte(tbl[k].b[i]);
      for (int i = 0; i < tbl[k].xbits; i++) step(1'b0);
      send_flag();
      repeat (4) step(1'b1);
      check($sformatf("frame%0d_eof", k), n_eof - s0, 1);
      check($sformatf("frame%0d_ferr", k), n_ferr - s1, tbl[k].ferr);
      check($sformatf("frame%0d_newbytes", k), n_nb - s2, tbl[k].n);
      check($sformatf("frame%0d_bytecount", k), bus.Rx_ByteCount, CNT_ON ? tbl[k].cnt : 0);
      check($sformatf("frame%0d_valid_low", k), bus.Rx_ValidFrame, 0);
    end
    // abort after the first byte of a frame
    s0 = n_eof; s1 = n_abort; s2 = n_nb;
    send_flag();
    send_byte(8'h11);
    step(1'b0);
    for (int i = 0; i < 7; i++) step(1'b1);
    ta = bitcyc;
    repeat (6) step(1'b1);
    check("abort_count", n_abort - s1, 1);
    check("abort_latency", abort_cyc - ta, 2);
    check("abort_eof", n_eof - s0, 1);
    check("abort_newbytes", n_nb - s2, 1);
    check("abort_valid_low", bus.Rx_ValidFrame, 0);
    // receiver disabled mid-frame
    s0 = n_eof; s1 = n_ferr; s2 = n_nb;
    send_flag();
    send_byte(8'h5A);
    repeat (9) step(1'b0);
    check("valid_before_disable", bus.Rx_ValidFrame, 1);
    s3 = n_flag + n_abort;
    bus.RxEN = 1'b0;
    repeat (4) step(1'b0);
    check("disable_valid_low", bus.Rx_ValidFrame, 0);
    bus.RxEN = 1'b1;
    repeat (12) step(1'b1);
    check("disable_eof", n_eof - s0, 1);
    check("disable_no_ferr", n_ferr - s1, 0);
    check("disable_newbytes", n_nb - s2, 1);
    check("disable_no_pulses", n_flag + n_abort - s3, 0);
    // asynchronous reset mid-frame
    s0 = n_eof;
    send_flag();
    send_byte(8'h96);
    repeat (9) step(1'b0);
    check("valid_before_reset", bus.Rx_ValidFrame, 1);
    #3 Rst = 1'b0;
    #1;
    check("reset_midframe_outputs", {bus.Rx_Data, bus.Rx_NewByte, bus.Rx_ValidFrame, bus.Rx_FlagDetect,
      bus.Rx_AbortDetect, bus.Rx_EoF, bus.Rx_FrameError, bus.Rx_ByteCount}, 0);
    vf_p1 = 1'b0;
    vf_p2 = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (6) step(1'b1);
    check("reset_no_eof", n_eof - s0, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
